// File: rtl/nonrestore_div_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// start/done handshake, held results, divide-by-zero flag.
module nonrestore_div_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dl_q, dl_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    // Divide-by-zero request seen last edge; result is published on this edge.
    logic             dzp_q, dzp_d;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   dl_ext;
    logic [WIDTH:0]   a_step;

    assign s      = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
    assign dl_ext = {1'b0, dl_q};
    assign a_step = a_q[WIDTH] ? (s + dl_ext) : (s - dl_ext);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;
        dl_d    = dl_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        dzp_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dzp_q) begin
                    q_d    = '1;
                    r_d    = qr_q;
                    dz_d   = 1'b1;
                    done_d = 1'b1;
                end
                if (start) begin
                    // QR doubles as the dividend latch for the divide-by-zero path.
                    qr_d = N;
                    if (D != '0) begin
                        a_d     = '0;
                        dl_d    = D;
                        cnt_d   = CntW'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end else begin
                        dzp_d = 1'b1;
                    end
                end
            end
            StRun: begin
                a_d   = a_step;
                qr_d  = {qr_q[WIDTH-2:0], ~a_step[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // A negative final partial remainder needs one add-back.
                r_d     = a_q[WIDTH] ? (a_q[WIDTH-1:0] + dl_q) : a_q[WIDTH-1:0];
                q_d     = qr_q;
                dz_d    = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            dl_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dzp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dzp_q   <= dzp_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_nonrestore_div_seq.sv
// Randomised self-checking bench for nonrestore_div_seq against a / and % reference.
module tb_nonrestore_div_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] N;
    logic [W-1:0] D;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dz;

    int n_vec;
    int n_err;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_dz;

    nonrestore_div_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .N    (N),
        .D    (D),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R),
        .dz   (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request at the current point (just after a rising edge) and follow it to done.
    task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d, input bit noise);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           lat;
        int           k;
        bit           seen;
        if (d == 0) begin
            eq  = '1;
            er  = n;
            edz = 1'b1;
            lat = 1;
        end else begin
            eq  = n / d;
            er  = n % d;
            edz = 1'b0;
            lat = W + 1;
        end
        start = 1'b1;
        N     = n;
        D     = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        N     = W'($urandom);
        D     = W'($urandom);
        check("done_low_after_start", {31'b0, done}, 32'(0));
        check("busy_after_start", {31'b0, busy}, {31'b0, d != 0});
        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            if (noise && (k == 2 || k == 4)) begin
                start = 1'b1;
                N     = W'($urandom);
                D     = W'($urandom_range(1, 255));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
            if (done) begin
                seen = 1;
            end else begin
                check("busy_during", {31'b0, busy}, {31'b0, d != 0});
                check("q_hold", 32'(Q), 32'(prev_q));
                check("r_hold", 32'(R), 32'(prev_r));
                check("dz_hold", {31'b0, dz}, {31'b0, prev_dz});
            end
        end
        check("done_seen", {31'b0, seen}, 32'(1));
        check("latency", 32'(k), 32'(lat));
        check("busy_at_done", {31'b0, busy}, 32'(0));
        check("quotient", 32'(Q), 32'(eq));
        check("remainder", 32'(R), 32'(er));
        check("dz_flag", {31'b0, dz}, {31'b0, edz});
        prev_q  = eq;
        prev_r  = er;
        prev_dz = edz;
    endtask

    initial begin
        logic [W-1:0] rn;
        logic [W-1:0] rd;
        bit           done_after_rst;
        n_vec   = 0;
        n_err   = 0;
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        N       = '0;
        D       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'(0));
        check("rst_done", {31'b0, done}, 32'(0));
        check("rst_q", 32'(Q), 32'(0));
        check("rst_r", 32'(R), 32'(0));
        check("rst_dz", {31'b0, dz}, 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_div(8'd200, 8'd7, 0);
        do_div(8'd255, 8'd1, 0);
        do_div(8'd5, 8'd9, 0);
        do_div(8'd13, 8'd0, 0);
        do_div(8'd9, 8'd3, 0);
        do_div(8'd0, 8'd0, 0);
        do_div(8'd0, 8'd5, 0);
        do_div(8'd200, 8'd7, 1);
        do_div(8'd255, 8'd255, 0);
        do_div(8'd254, 8'd255, 0);

        for (int i = 0; i < 1500; i++) begin
            rn = W'($urandom);
            if ($urandom_range(0, 15) == 0) rd = '0;
            else if ($urandom_range(0, 3) == 0) rd = W'($urandom_range(1, 15));
            else rd = W'($urandom);
            do_div(rn, rd, (rd != 0) && ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a divide.
        start = 1'b1;
        N     = 8'd200;
        D     = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'(0));
        check("midrst_done", {31'b0, done}, 32'(0));
        check("midrst_q", 32'(Q), 32'(0));
        check("midrst_r", 32'(R), 32'(0));
        check("midrst_dz", {31'b0, dz}, 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_after_rst = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_after_rst = 1;
        end
        check("no_done_after_abort", {31'b0, done_after_rst}, 32'(0));
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        do_div(8'd100, 8'd10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
